// File: rtl/finish_writeback_pkg.sv
// Shared definitions for the FINISH write-back stage: sequencer state
// encodings, default bus widths and this block's FSM state constants.
package finish_writeback_pkg;

    // Sequencer state encoding, shared with the rest of the multi-cycle CPU.
    localparam int                    STATE_SIZE   = 4;
    localparam logic [STATE_SIZE-1:0] FETCH_BEGIN  = 4'd0;
    localparam logic [STATE_SIZE-1:0] DECODE_BEGIN = 4'd3;
    localparam logic [STATE_SIZE-1:0] FINISH_BEGIN = 4'd9;

    // Default memory bus widths.
    localparam int ADDR_SIZE = 32;
    localparam int DATA_SIZE = 32;

    // FINISH controller FSM states.
    localparam int         FSM_W     = 3;
    localparam logic [2:0] FSM_IDLE  = 3'd0;
    localparam logic [2:0] FSM_SCAN  = 3'd1;
    localparam logic [2:0] FSM_REQ   = 3'd2;
    localparam logic [2:0] FSM_WRITE = 3'd3;
    localparam logic [2:0] FSM_REL   = 3'd4;
    localparam logic [2:0] FSM_DONE  = 3'd5;
    localparam logic [2:0] FSM_HOLD  = 3'd6;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/finish_writeback_lowest_bit_sel.sv
// Priority encoder: index of the lowest set bit of req, plus an any-set flag.
module lowest_bit_sel
    import finish_writeback_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int IDX_W = idx_width(NCH)
) (
    input  logic [NCH-1:0]   req,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk from the top bit down so the lowest set bit is the last to win.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        idx = '0;
        any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/finish_writeback.sv
// FINISH-stage controller: on FINISH_BEGIN, writes each valid result channel
// back to memory over the shared tri-state bus (lowest index first), then
// pulses the shared next_state line once per sequencer visit.
// Optional: define FINISH_TIMEOUT_EN to add a TMO_W-bit write watchdog that
// drops a stalled channel and sets the sticky err flag.
module finish_writeback
    import finish_writeback_pkg::*;
#(
    parameter int ADDR_W = ADDR_SIZE,
    parameter int DATA_W = DATA_SIZE,
    parameter int NCH    = 4,
    parameter int TMO_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STATE_SIZE-1:0] state,
    input  logic [NCH-1:0]        wb_valid,
    input  logic [NCH*ADDR_W-1:0] wb_addr,
    input  logic [NCH*DATA_W-1:0] wb_data,
    output logic                  bus_req,
    input  logic                  bus_grant,
    inout  wire                   is_bus_busy,
    inout  wire  [ADDR_W-1:0]     addr,
    inout  wire  [DATA_W-1:0]     data,
    output logic                  write_q,
    input  logic                  write_dn,
    inout  wire                   next_state,
    output logic [NCH-1:0]        wb_done,
    output logic                  err
);

    localparam int IDX_W = idx_width(NCH);

    logic [FSM_W-1:0]  fsm;
    logic [NCH-1:0]    pend;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              tmo_hit;

    lowest_bit_sel #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_sel (
        .req (pend),
        .idx (sel_idx),
        .any (sel_any)
    );

`ifdef FINISH_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Watchdog: zero outside WRITE, so it starts from zero on every WRITE entry.
    always_ff @(posedge clk) begin
        if (rst || fsm != FSM_WRITE) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + TMO_W'(1);
    end

    // An acknowledge on the last watchdog cycle still wins over the timeout.
    assign tmo_hit = (fsm == FSM_WRITE) && (&tmo_cnt) && !write_dn;

    // Sticky timeout flag, cleared when a new finish latches its channels.
    always_ff @(posedge clk) begin
        if (rst)                                             err_q <= 1'b0;
        else if (fsm == FSM_IDLE && state == FINISH_BEGIN)   err_q <= 1'b0;
        else if (tmo_hit)                                    err_q <= 1'b1;
    end

    assign err = err_q;
`else
    // Without the watchdog WRITE waits for write_dn forever and err never sets;
    // TMO_W only gates this tie-off so the parameter stays part of the interface.
    if (TMO_W >= 0) begin : g_no_watchdog
        assign tmo_hit = 1'b0;
    end
    assign err = 1'b0;
`endif

    // Control FSM: latch requests, walk channels lowest-first, then pulse once.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            fsm     <= FSM_IDLE;
            pend    <= '0;
            wb_done <= '0;
            idx_q   <= '0;
        end else begin
            case (fsm)
                FSM_IDLE: begin
                    if (state == FINISH_BEGIN) begin
                        pend    <= wb_valid;
                        wb_done <= '0;
                        fsm     <= FSM_SCAN;
                    end
                end
                FSM_SCAN: begin
                    if (!sel_any) begin
                        fsm <= FSM_DONE;
                    end else begin
                        idx_q <= sel_idx;
                        fsm   <= FSM_REQ;
                    end
                end
                FSM_REQ: begin
                    if (bus_grant) fsm <= FSM_WRITE;
                end
                FSM_WRITE: begin
                    if (write_dn) begin
                        pend[idx_q]    <= 1'b0;
                        wb_done[idx_q] <= 1'b1;
                        fsm            <= FSM_REL;
                    end else if (tmo_hit) begin
                        pend[idx_q] <= 1'b0;
                        fsm         <= FSM_REL;
                    end
                end
                FSM_REL:  fsm <= FSM_SCAN;
                FSM_DONE: fsm <= FSM_HOLD;
                FSM_HOLD: begin
                    if (state != FINISH_BEGIN) fsm <= FSM_IDLE;
                end
                default:  fsm <= FSM_IDLE;
            endcase
        end
    end

    // Capture the selected channel's address and data while scanning.
    always_ff @(posedge clk) begin
        // NOTE: datapath holding registers are not reset; SCAN always loads them
        // before WRITE can put them on the bus.
        if (fsm == FSM_SCAN && sel_any) begin
            addr_q <= wb_addr[int'(sel_idx) * ADDR_W +: ADDR_W];
            data_q <= wb_data[int'(sel_idx) * DATA_W +: DATA_W];
        end
    end

    // Bus outputs decode straight from the FSM; shared lines float when unused.
    assign bus_req     = (fsm == FSM_REQ) || (fsm == FSM_WRITE);
    assign write_q     = (fsm == FSM_WRITE);
    assign is_bus_busy = write_q ? 1'b1 : 1'bz;
    assign addr        = write_q ? addr_q : 'z;
    assign data        = write_q ? data_q : 'z;
    assign next_state  = (fsm == FSM_DONE) ? 1'b1 : 1'bz;

endmodule

// File: doc/finish_writeback.md
# finish_writeback

Parametrised FINISH-stage controller for the multi-cycle CPU pipeline. When the sequencer enters `FINISH_BEGIN`, the block writes up to `NCH` result operands back to memory over the shared tri-state memory bus, one at a time and lowest index first. It arbitrates for the bus with a req/grant handshake, then pulses the shared `next_state` line so the sequencer can advance. It replaces the single-shot finish stage, which only signalled completion and never wrote results back.

## Interface
Parameters:
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: bus data width.
- `NCH`, 4: number of write-back channels (1..8).
- `TMO_W`, 8: watchdog counter width. Used only with `FINISH_TIMEOUT_EN`.

Ports:
- `clk`  in  1: clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `state`  in  `STATE_SIZE`: sequencer state. The block acts only in `FINISH_BEGIN`.
- `wb_valid`  in  `NCH`: per-channel write-back request.
- `wb_addr`  in  `NCH*ADDR_W`: channel i target address, at bits [i*ADDR_W +: ADDR_W].
- `wb_data`  in  `NCH*DATA_W`: channel i data, packed the same way.
- `bus_req`  out  1: bus request to the arbiter.
- `bus_grant`  in  1: bus granted.
- `is_bus_busy`  inout  1: driven 1 while this block owns the bus, otherwise z.
- `addr`  inout  `ADDR_W`: bus address, driven only in WRITE, otherwise z.
- `data`  inout  `DATA_W`: bus data, driven only in WRITE, otherwise z.
- `write_q`  out  1: write strobe to memory.
- `write_dn`  in  1: memory write acknowledge.
- `next_state`  inout  1: shared advance line. Driven 1 for one cycle in DONE, otherwise z.
- `wb_done`  out  `NCH`: mask of channels written in the current or last finish.
- `err`  out  1: sticky write-timeout flag. Cleared only by reset or by a new finish.

## Operation
FSM states: IDLE, SCAN, REQ, WRITE, REL, DONE, HOLD.
- **IDLE**: on `state==FINISH_BEGIN`:
  - latch `pend <= wb_valid`;
  - clear `wb_done`;
  - clear `err`;
  - go to SCAN.
  - Changes to `wb_valid` after this latch are ignored.
- **SCAN**:
  - `pend==0`: go to DONE.
  - Otherwise select `idx` = lowest set bit of `pend`, register `addr`/`data` from that channel, go to REQ.
- **REQ**: assert `bus_req`. On `bus_grant` high, go to WRITE.
- **WRITE**:
  - hold `bus_req`;
  - drive `is_bus_busy=1`, `addr`, `data`, `write_q=1`;
  - on `write_dn` high: clear `pend[idx]`, set `wb_done[idx]`, go to REL.
  - Losing grant mid-write is ignored; the write completes.
- **REL**: release all bus lines to z and drop `bus_req`/`write_q`, go to SCAN. Consecutive writes therefore always have one idle bus cycle between them.
- **DONE**: drive `next_state=1` for exactly one cycle, go to HOLD.
- **HOLD**: wait while `state==FINISH_BEGIN`, then go to IDLE. This guarantees one finish per sequencer visit.
- **`state` leaving `FINISH_BEGIN` early** (in SCAN/REQ/WRITE): the current operation completes; DONE's pulse is still issued.
- **Reset**, at any time including mid-write:
  - FSM to IDLE, `pend=0`, `wb_done=0`, `err=0`;
  - `bus_req=0`, `write_q=0`;
  - `addr`/`data`/`is_bus_busy`/`next_state` to z.

## Timing
- Zero valid channels: `FINISH_BEGIN` seen at cycle 0 → SCAN at 1 → DONE at 2, so the `next_state` pulse is at cycle 2.
- Per channel: SCAN 1 cycle + REQ (≥1 cycle, until grant) + WRITE (≥1 cycle, until `write_dn`) + REL 1 cycle.
- Best case per channel is 4 cycles when grant and `write_dn` are both high on arrival.
- Total best case for k channels: 4k+2 cycles until the pulse.
- `bus_req` rises the cycle after SCAN and falls in REL.
- `write_q` is high only in WRITE.
- The acknowledge is sampled, not combinationally forwarded.

## Configuration
`FINISH_TIMEOUT_EN`:
- **Defined**: a `TMO_W`-bit counter runs in WRITE and clears on entry to WRITE.
  - On reaching all-ones without `write_dn`: set `err`, drop the channel (clear `pend[idx]`, leave `wb_done[idx]` at 0), go to REL.
  - Remaining channels continue.
- **Undefined**: no counter; WRITE waits indefinitely and `err` is tied to 0.

## Structure
- The shared package/include holds:
  - the `STATE_SIZE` and `FINISH_BEGIN` encodings, from the existing state definitions;
  - the FSM state localparams of this block;
  - the default width constants `ADDR_SIZE`/`DATA_SIZE`.
- One sub-module is natural: `lowest_bit_sel`, a parametrised `NCH`-input priority encoder giving `idx` and `any`.

## Test plan
- **All four channels**: `wb_valid=4'b1011`, addrs 0x100/0x104/–/0x10C, data 0xA/0xB/–/0xD; grant and `write_dn` tied 1.
  - Required: three writes, in order idx 0, 1, 3.
  - `next_state` pulse at cycle 14; `wb_done=4'b1011`.
- **Zero valid**: `wb_valid=0`. Required: no `bus_req`, pulse at cycle 2, `wb_done=0`.
- **Late grant and ack**: one channel; grant delayed 5 cycles, `write_dn` delayed 3 cycles.
  - Required: `addr`/`data` stable throughout WRITE, `is_bus_busy=1` only in WRITE, z elsewhere.
- **Reset mid-write**: assert `rst` in WRITE.
  - Required: next cycle all bus lines z, `bus_req=0`, `wb_done=0`.
  - Holding `FINISH_BEGIN` afterwards restarts from the `pend` latch.
- **Single finish per visit**: hold `state=FINISH_BEGIN` for 50 cycles with `wb_valid=1`.
  - Required: exactly one write and one pulse.
- **Timeout (with `FINISH_TIMEOUT_EN`, `TMO_W=4`)**: `write_dn` held 0 on channel 0, 1 on channel 1.
  - Required: `err=1`, `wb_done=2'b10`, pulse still issued.
